// File: rtl/main_exp32.sv
// rtl/main_exp32.sv - single-cycle MIPS-style ALU with registered result, zero flag and branch offset
module main_exp32 (
    input  logic        clk,
    input  logic        rst,
    input  logic [0:1]  ALUop,
    input  logic [0:31] RD1,
    input  logic [0:31] RD2,
    input  logic [0:31] SE,
    output logic        Zero,
    output logic [0:31] Out,
    output logic [0:31] Out2
);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_SLT = 3'd4;

    logic [0:5]  w_funct;
    logic [2:0]  w_op;
    logic [0:31] w_b;
    logic [0:31] w_result;
    logic [0:31] w_offset;

    logic        r_zero;
    logic [0:31] r_out;
    logic [0:31] r_out2;

    assign w_funct  = SE[26:31];
    // Only the register-based classes (01, 10) take RD2 as operand B.
    assign w_b      = (ALUop[0] ^ ALUop[1]) ? RD2 : SE;
    assign w_offset = {SE[2:31], 2'b00};

    always_comb begin
        w_op = OP_ADD;
        case (ALUop)
            2'b01: w_op = OP_SUB;
            2'b10: begin
                case (w_funct)
                    6'b100000: w_op = OP_ADD;
                    6'b100010: w_op = OP_SUB;
                    6'b100100: w_op = OP_AND;
                    6'b100101: w_op = OP_OR;
                    6'b101010: w_op = OP_SLT;
                    default:   w_op = OP_ADD;
                endcase
            end
            default: w_op = OP_ADD;
        endcase
    end

    always_comb begin
        w_result = '0;
        case (w_op)
            OP_SUB:  w_result = RD1 - w_b;
            OP_AND:  w_result = RD1 & w_b;
            OP_OR:   w_result = RD1 | w_b;
            OP_SLT:  w_result = ($signed(RD1) < $signed(w_b)) ? 32'd1 : 32'd0;
            default: w_result = RD1 + w_b;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out  <= '0;
            r_out2 <= '0;
            r_zero <= 1'b1;
        end else begin
            r_out  <= w_result;
            r_out2 <= w_offset;
            r_zero <= (w_result == 32'd0);
        end
    end

    assign Out  = r_out;
    assign Out2 = r_out2;
    assign Zero = r_zero;

endmodule

// File: tb/tb_main_exp32.sv
// tb/tb_main_exp32.sv - directed table-driven bench for main_exp32
module tb_main_exp32;

    logic        clk;
    logic        rst;
    logic [0:1]  ALUop;
    logic [0:31] RD1;
    logic [0:31] RD2;
    logic [0:31] SE;
    logic        Zero;
    logic [0:31] Out;
    logic [0:31] Out2;

    int n_checks;
    int n_fail;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] se;
        logic [31:0] exp_out;
        logic [31:0] exp_out2;
        logic        exp_zero;
    } vec_t;

    localparam int NVEC = 16;
    vec_t vecs[NVEC];

    main_exp32 dut (
        .clk  (clk),
        .rst  (rst),
        .ALUop(ALUop),
        .RD1  (RD1),
        .RD2  (RD2),
        .SE   (SE),
        .Zero (Zero),
        .Out  (Out),
        .Out2 (Out2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        ALUop = v.op;
        RD1   = v.rd1;
        RD2   = v.rd2;
        SE    = v.se;
    endtask

    task automatic check_vec(input string tag, input vec_t v);
        check({tag, " Out"},  Out,  v.exp_out);
        check({tag, " Out2"}, Out2, v.exp_out2);
        check({tag, " Zero"}, {31'd0, Zero}, {31'd0, v.exp_zero});
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " Out"},  Out,  32'd0);
        check({tag, " Out2"}, Out2, 32'd0);
        check({tag, " Zero"}, {31'd0, Zero}, 32'd1);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;

        vecs[0]  = '{2'b10, 32'd5,        32'd6,        32'h20,       32'd11,        32'h80,   1'b0};
        vecs[1]  = '{2'b10, 32'd5,        32'd6,        32'h22,       32'hFFFFFFFF,  32'h88,   1'b0};
        vecs[2]  = '{2'b10, 32'd5,        32'd6,        32'h24,       32'd4,         32'h90,   1'b0};
        vecs[3]  = '{2'b10, 32'd5,        32'd6,        32'h25,       32'd7,         32'h94,   1'b0};
        vecs[4]  = '{2'b10, 32'd5,        32'd6,        32'h2A,       32'd1,         32'hA8,   1'b0};
        vecs[5]  = '{2'b10, 32'hFFFFFFFF, 32'd1,        32'h2A,       32'd1,         32'hA8,   1'b0};
        vecs[6]  = '{2'b10, 32'd1,        32'hFFFFFFFF, 32'h2A,       32'd0,         32'hA8,   1'b1};
        vecs[7]  = '{2'b00, 32'd5,        32'd99,       32'h10,       32'd21,        32'h40,   1'b0};
        vecs[8]  = '{2'b01, 32'd9,        32'd9,        32'h1234,     32'd0,         32'h48D0, 1'b1};
        vecs[9]  = '{2'b11, 32'hFFFFFFFF, 32'd7,        32'd1,        32'd0,         32'h4,    1'b1};
        vecs[10] = '{2'b10, 32'd5,        32'd6,        32'h3F,       32'd11,        32'hFC,   1'b0};
        vecs[11] = '{2'b10, 32'h80000000, 32'd1,        32'h22,       32'h7FFFFFFF,  32'h88,   1'b0};
        vecs[12] = '{2'b00, 32'd0,        32'd5,        32'hC0000001, 32'hC0000001,  32'h4,    1'b0};
        vecs[13] = '{2'b10, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'h24,       32'd0,         32'h90,   1'b1};
        vecs[14] = '{2'b10, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'h25,       32'hFFFFFFFF,  32'h94,   1'b0};
        vecs[15] = '{2'b01, 32'd10,       32'd3,        32'd100,      32'd7,         32'h190,  1'b0};

        rst = 1'b1;
        drive(vecs[0]);
        #3;
        check_reset_state("reset_initial");

        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            @(posedge clk);
            #1;
            check_vec($sformatf("vec%0d", i), vecs[i]);
        end

        // Async reset between edges while Out = 11
        @(negedge clk);
        drive(vecs[0]);
        @(posedge clk);
        #1;
        check("pre_async Out", Out, 32'd11);
        #2;
        rst = 1'b1;
        #1;
        check_reset_state("async_reset");
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_vec("after_async", vecs[0]);

        // Reset held across an edge discards the pending result; no stale value after release
        @(negedge clk);
        drive(vecs[1]);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_state("reset_over_edge");
        @(negedge clk);
        rst = 1'b0;
        drive(vecs[7]);
        #2;
        check_reset_state("released_no_edge");
        @(posedge clk);
        #1;
        check_vec("first_after_release", vecs[7]);

        // Unknown ALUop: data unspecified, Out2 still defined, then recovery
        @(negedge clk);
        drive(vecs[3]);
        ALUop = 2'bxx;
        @(posedge clk);
        #1;
        check("x_op Out2", Out2, 32'h94);
        @(negedge clk);
        drive(vecs[4]);
        @(posedge clk);
        #1;
        check_vec("x_recover", vecs[4]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
